// File: rtl/resz_dis_ctl.sv
// Multi-channel shadow/active value controller with holdoff disable override.
// Optional RESZ_CLAMP_EN clamps loaded values into [MIN, MAX].
module resz_dis_ctl #(
   parameter int              CHANNELS = 2,
   parameter int              WIDTH    = 32,
   parameter logic [WIDTH-1:0] DEFAULT = 'h10,
   parameter logic [WIDTH-1:0] MIN     = 'h4,
   parameter logic [WIDTH-1:0] MAX     = 'h400,
   parameter int              HOLDOFF  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] Res_line,
   input  logic [CHANNELS-1:0]       Load,
   input  logic                      Commit,
   input  logic [CHANNELS-1:0]       Disable,
   output logic [CHANNELS*WIDTH-1:0] Output,
   output logic [CHANNELS-1:0]       Pending,
   output logic [CHANNELS-1:0]       Forced,
   output logic [CHANNELS-1:0]       Clamped
);

   typedef enum logic [1:0] {RUN, HOLD, DIS} st_t;

   localparam logic [7:0] HOLD_N = 8'(HOLDOFF);

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] raw;
      logic [WIDTH-1:0] load_v;
      logic [WIDTH-1:0] shadow_q;
      logic [WIDTH-1:0] active_q;
      logic [WIDTH-1:0] active_d;
      logic [WIDTH-1:0] out_q;
      logic [WIDTH-1:0] out_d;
      logic             pend_q;
      logic             pend_d;
      logic [7:0]       cnt_q;
      logic [7:0]       cnt_d;
      st_t              st_q;
      st_t              st_d;

      assign raw = Res_line[gi*WIDTH +: WIDTH];

`ifdef RESZ_CLAMP_EN
      logic clip;
      logic clip_q;

      always_comb begin
         load_v = raw;
         clip   = 1'b0;
         if (raw < MIN) begin
            load_v = MIN;
            clip   = 1'b1;
         end else if (raw > MAX) begin
            load_v = MAX;
            clip   = 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) clip_q <= 1'b0;
         else      clip_q <= Load[gi] & clip;
      end

      assign Clamped[gi] = clip_q;
`else
      logic unused_bounds;

      assign load_v        = raw;
      assign Clamped[gi]   = 1'b0;
      assign unused_bounds = ^{MIN, MAX};
`endif

      always_comb begin
         st_d  = st_q;
         cnt_d = cnt_q;
         unique case (st_q)
            RUN: begin
               if (Disable[gi]) begin
                  if (HOLD_N == 8'd0) begin
                     st_d = DIS;
                  end else begin
                     st_d  = HOLD;
                     cnt_d = 8'd1;
                  end
               end
            end
            HOLD: begin
               if (!Disable[gi]) begin
                  st_d  = RUN;
                  cnt_d = 8'd0;
               end else if (cnt_q == HOLD_N) begin
                  st_d = DIS;
               end else if (cnt_q != 8'hff) begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            DIS: begin
               if (!Disable[gi]) begin
                  st_d  = RUN;
                  cnt_d = 8'd0;
               end
            end
            default: begin
               st_d  = RUN;
               cnt_d = 8'd0;
            end
         endcase
      end

      // Load+Commit together bypasses the shadow straight into active.
      always_comb begin
         active_d = active_q;
         pend_d   = pend_q;
         if (Commit) begin
            pend_d = 1'b0;
            if (Load[gi])    active_d = load_v;
            else if (pend_q) active_d = shadow_q;
         end else if (Load[gi]) begin
            pend_d = 1'b1;
         end
         out_d = (st_d == DIS) ? DEFAULT : active_d;
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            shadow_q <= DEFAULT;
            active_q <= DEFAULT;
            out_q    <= DEFAULT;
            pend_q   <= 1'b0;
            cnt_q    <= 8'd0;
            st_q     <= RUN;
         end else begin
            if (Load[gi]) shadow_q <= load_v;
            active_q <= active_d;
            out_q    <= out_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            st_q     <= st_d;
         end
      end

      assign Output[gi*WIDTH +: WIDTH] = out_q;
      assign Pending[gi]               = pend_q;
      assign Forced[gi]                = (st_q == DIS);
   end

endmodule

// File: tb/tb_resz_dis_ctl.sv
// Directed scoreboard bench for resz_dis_ctl (default parameters).
// Expectations follow RESZ_CLAMP_EN when the bench is built with it.
module tb_resz_dis_ctl;

   logic        clk;
   logic        rst;
   logic [63:0] Res_line;
   logic [1:0]  Load;
   logic        Commit;
   logic [1:0]  Disable;
   logic [63:0] Output;
   logic [1:0]  Pending;
   logic [1:0]  Forced;
   logic [1:0]  Clamped;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [63:0] out;
      logic [1:0]  pend;
      logic [1:0]  forc;
      logic [1:0]  clmp;
   } exp_t;

   exp_t sb[$];

`ifdef RESZ_CLAMP_EN
   localparam logic [31:0] LO_V  = 32'h4;
   localparam logic [31:0] HI_V  = 32'h400;
   localparam logic [1:0]  CL_P  = 2'b01;
`else
   localparam logic [31:0] LO_V  = 32'h1;
   localparam logic [31:0] HI_V  = 32'h10000;
   localparam logic [1:0]  CL_P  = 2'b00;
`endif

   resz_dis_ctl dut (
      .clk      (clk),
      .rst      (rst),
      .Res_line (Res_line),
      .Load     (Load),
      .Commit   (Commit),
      .Disable  (Disable),
      .Output   (Output),
      .Pending  (Pending),
      .Forced   (Forced),
      .Clamped  (Clamped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic push(input string tag, input logic [31:0] e0,
                       input logic [31:0] e1, input logic [1:0] ep,
                       input logic [1:0] ef, input logic [1:0] ec);
      exp_t e;
      e.tag  = tag;
      e.out  = {e1, e0};
      e.pend = ep;
      e.forc = ef;
      e.clmp = ec;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL scoreboard_empty: got 0 entries, need 1");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert (Output === e.out) else begin
            errors++;
            $error("FAIL %s out: got %h need %h", e.tag, Output, e.out);
         end
         checks++;
         assert (Pending === e.pend) else begin
            errors++;
            $error("FAIL %s pend: got %b need %b", e.tag, Pending, e.pend);
         end
         checks++;
         assert (Forced === e.forc) else begin
            errors++;
            $error("FAIL %s forced: got %b need %b", e.tag, Forced, e.forc);
         end
         checks++;
         assert (Clamped === e.clmp) else begin
            errors++;
            $error("FAIL %s clamp: got %b need %b", e.tag, Clamped, e.clmp);
         end
      end
   endtask

   task automatic step(input string tag, input logic [1:0] ld,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic cm, input logic [1:0] ds,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] ep, input logic [1:0] ef,
                       input logic [1:0] ec);
      Load     = ld;
      Res_line = {d1, d0};
      Commit   = cm;
      Disable  = ds;
      push(tag, e0, e1, ep, ef, ec);
      @(posedge clk);
      #1;
      check();
      Load   = 2'b00;
      Commit = 1'b0;
   endtask

   initial begin
      rst      = 1'b0;
      Res_line = '0;
      Load     = '0;
      Commit   = 1'b0;
      Disable  = '0;
      #12;
      push("reset", 32'h10, 32'h10, 2'b00, 2'b00, 2'b00);
      check();
      rst = 1'b1;
      for (int i = 0; i < 5; i++)
         step("idle", 2'b00, 0, 0, 0, 2'b00,
              32'h10, 32'h10, 2'b00, 2'b00, 2'b00);

      step("ld0", 2'b01, 32'h80, 0, 0, 2'b00,
           32'h10, 32'h10, 2'b01, 2'b00, 2'b00);
      step("ld0_wait", 2'b00, 0, 0, 0, 2'b00,
           32'h10, 32'h10, 2'b01, 2'b00, 2'b00);
      step("commit0", 2'b00, 0, 0, 1, 2'b00,
           32'h80, 32'h10, 2'b00, 2'b00, 2'b00);
      step("ldcm1", 2'b10, 0, 32'h200, 1, 2'b00,
           32'h80, 32'h200, 2'b00, 2'b00, 2'b00);
      step("commit_nop", 2'b00, 0, 0, 1, 2'b00,
           32'h80, 32'h200, 2'b00, 2'b00, 2'b00);

      for (int i = 0; i < 3; i++)
         step("hold", 2'b00, 0, 0, 0, 2'b01,
              32'h80, 32'h200, 2'b00, 2'b00, 2'b00);
      step("dis", 2'b00, 0, 0, 0, 2'b01,
           32'h10, 32'h200, 2'b00, 2'b01, 2'b00);
      step("dis_stay", 2'b00, 0, 0, 0, 2'b01,
           32'h10, 32'h200, 2'b00, 2'b01, 2'b00);
      step("undis", 2'b00, 0, 0, 0, 2'b00,
           32'h80, 32'h200, 2'b00, 2'b00, 2'b00);

      for (int i = 0; i < 2; i++)
         step("pulse", 2'b00, 0, 0, 0, 2'b01,
              32'h80, 32'h200, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++)
         step("pulse_end", 2'b00, 0, 0, 0, 2'b00,
              32'h80, 32'h200, 2'b00, 2'b00, 2'b00);

      for (int i = 0; i < 3; i++)
         step("hold2", 2'b00, 0, 0, 0, 2'b01,
              32'h80, 32'h200, 2'b00, 2'b00, 2'b00);
      step("dis2", 2'b00, 0, 0, 0, 2'b01,
           32'h10, 32'h200, 2'b00, 2'b01, 2'b00);
      step("ld_in_dis", 2'b01, 32'h90, 0, 0, 2'b01,
           32'h10, 32'h200, 2'b01, 2'b01, 2'b00);
      step("cm_in_dis", 2'b00, 0, 0, 1, 2'b01,
           32'h10, 32'h200, 2'b00, 2'b01, 2'b00);
      step("undis2", 2'b00, 0, 0, 0, 2'b00,
           32'h90, 32'h200, 2'b00, 2'b00, 2'b00);

      step("ld_lo", 2'b01, 32'h1, 0, 0, 2'b00,
           32'h90, 32'h200, 2'b01, 2'b00, CL_P);
      step("cm_lo", 2'b00, 0, 0, 1, 2'b00,
           LO_V, 32'h200, 2'b00, 2'b00, 2'b00);
      step("ld_hi", 2'b01, 32'h10000, 0, 1, 2'b00,
           HI_V, 32'h200, 2'b00, 2'b00, CL_P);
      step("after_hi", 2'b00, 0, 0, 0, 2'b00,
           HI_V, 32'h200, 2'b00, 2'b00, 2'b00);
      step("ld_ok", 2'b10, 0, 32'h100, 0, 2'b00,
           HI_V, 32'h200, 2'b10, 2'b00, 2'b00);
      step("cm_ok", 2'b00, 0, 0, 1, 2'b00,
           HI_V, 32'h100, 2'b00, 2'b00, 2'b00);

      step("pend_hold", 2'b10, 0, 32'h33, 0, 2'b01,
           HI_V, 32'h100, 2'b10, 2'b00, 2'b00);
      step("hold3", 2'b00, 0, 0, 0, 2'b01,
           HI_V, 32'h100, 2'b10, 2'b00, 2'b00);
      #2;
      rst = 1'b0;
      #1;
      push("mid_reset", 32'h10, 32'h10, 2'b00, 2'b00, 2'b00);
      check();
      #2;
      rst = 1'b1;
      for (int i = 0; i < 3; i++)
         step("rst_hold", 2'b00, 0, 0, 0, 2'b01,
              32'h10, 32'h10, 2'b00, 2'b00, 2'b00);
      step("rst_dis", 2'b00, 0, 0, 0, 2'b01,
           32'h10, 32'h10, 2'b00, 2'b01, 2'b00);
      step("rst_undis", 2'b00, 0, 0, 0, 2'b00,
           32'h10, 32'h10, 2'b00, 2'b00, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/resz_dis_ctl.md
Name: resz_dis_ctl

Overview:
- Multi-channel resize/resolution value controller with registered disable override.
- Each channel has a shadow value, loaded at any time, and an active value, updated only on a Commit strobe (frame boundary).
- A per-channel disable state machine forces the output to DEFAULT after a programmable holdoff.
- Sits between the control bus (Res_line writers) and the size/resolution consumers.

Parameters:
- CHANNELS, 2: number of independent channels.
- WIDTH, 32: bits per channel value.
- DEFAULT, 32'h10: reset value and forced value while disabled.
- MIN, 32'h4: lower clamp bound (only with RESZ_CLAMP_EN).
- MAX, 32'h400: upper clamp bound (only with RESZ_CLAMP_EN). MIN <= DEFAULT <= MAX is required.
- HOLDOFF, 3: cycles of continuous Disable before the output is forced. Range 0..255.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous and active-low.
- Res_line, input, CHANNELS*WIDTH: per-channel load data; channel i is at [i*WIDTH +: WIDTH].
- Load, input, CHANNELS: per-channel shadow write strobe.
- Commit, input, 1: global frame-boundary strobe.
- Disable, input, CHANNELS: per-channel disable request (level).
- Output, output, CHANNELS*WIDTH: registered per-channel value.
- Pending, output, CHANNELS: shadow holds a value not yet committed.
- Forced, output, CHANNELS: channel is in state DIS.
- Clamped, output, CHANNELS: single-cycle pulse, load value was clamped.

Behaviour:
- Reset (rst low, async):
  - shadow = active = DEFAULT
  - Output = DEFAULT on all channels
  - Pending = 0, Forced = 0, Clamped = 0
  - state = RUN, holdoff counter = 0
- Load[i]=1: shadow[i] <= f(Res_line slice); Pending[i] <= 1. f is the clamp when RESZ_CLAMP_EN is defined, otherwise identity.
- Commit=1: for every channel with Pending=1, active <= shadow; Pending <= 0. Channels with Pending=0 are unchanged.
- Load[i] and Commit in the same cycle: the new f(value) is written to both shadow and active; Pending[i] = 0 afterwards.
- Per-channel FSM:
  - RUN: Output = active.
    - Disable=1 and HOLDOFF=0 -> DIS.
    - Disable=1 and HOLDOFF>0 -> HOLD, counter <= 1.
  - HOLD: Output = active.
    - Disable=0 -> RUN, counter <= 0.
    - Disable=1 and counter == HOLDOFF -> DIS.
    - Otherwise counter increments.
  - DIS: Output = DEFAULT, Forced = 1.
    - Disable=0 -> RUN.
- Output is registered. It reflects the state and active value after the clock edge: one cycle of latency from Commit or from a state change to Output.
- Load and Commit remain functional in HOLD and DIS. The active value updates silently and appears on RUN re-entry.
- Disable asserted continuously from reset: the first edge after reset release enters HOLD (or DIS if HOLDOFF=0).
- Channels are fully independent, apart from the shared Commit.
- The counter is 8 bits wide and saturates; it never wraps.

Optional Feature:
- Macro: RESZ_CLAMP_EN.
- Defined:
  - Loaded values below MIN are stored as MIN; values above MAX are stored as MAX.
  - Clamped[i] pulses high for one cycle, on the edge after the clamped Load.
- Undefined:
  - Values are stored unmodified and MIN/MAX are ignored.
  - Clamped is tied to 0.

Test Plan:
- Reset, then 5 idle cycles -> Output = {0x10, 0x10}; Pending = 0; Forced = 0.
- Load ch0 = 0x80, no Commit -> Output ch0 stays 0x10 and Pending[0] = 1. Commit one cycle later -> next cycle Output ch0 = 0x80, Pending[0] = 0.
- Load ch1 = 0x200 in the same cycle as Commit -> next cycle Output ch1 = 0x200, Pending[1] = 0.
- Disable ch0 held with HOLDOFF = 3 -> Output ch0 = 0x80 for 3 cycles, then 0x10 with Forced[0] = 1.
  - Deassert Disable -> next cycle Output ch0 = 0x80.
  - A Disable pulse of 2 cycles -> no forcing.
- With RESZ_CLAMP_EN: Load ch0 = 0x1 then Commit -> Output 0x4 and one Clamped[0] pulse. Load 0x10000 -> Output 0x400. Without the macro: Output 0x1, Clamped stays 0.
- Assert rst mid-HOLD with a pending value -> immediately Output = 0x10, state RUN, Pending = 0.
